radar_azimuth_sequencer: RTL

RADAR_AZIMUTH_SEQUENCER -- requirements
Module: radar_azimuth_sequencer

---
 rtl/radar_sim_pkg.sv | 16 +
 rtl/radar_period_counter.sv | 27 ++
 rtl/radar_azimuth_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/radar_sim_pkg.sv
// Shared widths, reset defaults and FSM state type for the radar azimuth sequencer.
package radar_sim_pkg;

   localparam int CNT_W = 24;
   localparam int AZ_W  = 16;

   localparam int unsigned DEFAULT_ACP_PERIOD  = 146484;
   localparam int unsigned DEFAULT_ACP_PER_ARP = 4096;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } seq_state_t;

endpackage

// File: rtl/radar_period_counter.sv
// Modulo counter with synchronous clear; wrap is high on the cycle the count rolls back to 0.
module radar_period_counter #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   assign wrap = enable && (count == (modulus - WIDTH'(1)));

   // Clear wins over counting so the owner can force the count home at any time.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= wrap ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/radar_azimuth_sequencer.sv
// Generates ACP/ARP azimuth pulses from a period counter and an azimuth counter,
// with a config port whose updates in flight are deferred to the revolution boundary.
module radar_azimuth_sequencer
   import radar_sim_pkg::*;
#(
   parameter int unsigned PULSE_LEN       = 100,
   parameter int unsigned DEF_ACP_PERIOD  = DEFAULT_ACP_PERIOD,
   parameter int unsigned DEF_ACP_PER_ARP = DEFAULT_ACP_PER_ARP
) (
   input  logic             IN_CLK,
   input  logic             IN_RESETN,
   input  logic             EN,
   input  logic [CNT_W-1:0] CFG_ACP_PERIOD,
   input  logic [AZ_W-1:0]  CFG_ACP_PER_ARP,
   input  logic             CFG_VALID,
   output logic             CFG_READY,
   output logic             CFG_ERR,
   output logic             RADAR_ACP,
   output logic             RADAR_ARP,
   output logic [AZ_W-1:0]  AZIMUTH,
   output logic             RUNNING
);

   localparam logic [CNT_W-1:0] PULSE_CNT  = CNT_W'(PULSE_LEN);
   localparam logic [CNT_W:0]   MIN_PERIOD = (CNT_W+1)'(2 * PULSE_LEN);

   seq_state_t       state, next_state;
   logic             to_idle;
   logic [CNT_W-1:0] cnt;
   logic             cnt_wrap;
   logic             rev_wrap;
   logic             ctr_clear;

   logic [CNT_W-1:0] act_period;
   logic [AZ_W-1:0]  act_per_arp;
   logic [CNT_W-1:0] pend_period;
   logic [AZ_W-1:0]  pend_per_arp;
   logic             pend_valid;
   logic             cfg_fire;
   logic             cfg_ok;
   logic             apply_pending;

   always_ff @(posedge IN_CLK) begin
      if (!IN_RESETN) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // DRAIN lets the current ACP period finish; EN coming back resumes without touching the counters.
   always_comb begin
      next_state = state;
      to_idle    = 1'b0;
      case (state)
         ST_IDLE:  if (EN) next_state = ST_RUN;
         ST_RUN:   if (!EN) next_state = ST_DRAIN;
         ST_DRAIN: begin
            if (EN) begin
               next_state = ST_RUN;
            end else if (cnt_wrap) begin
               next_state = ST_IDLE;
               to_idle    = 1'b1;
            end
         end
         default:  next_state = ST_IDLE;
      endcase
   end

   assign RUNNING   = (state != ST_IDLE);
   assign ctr_clear = (state == ST_IDLE) || to_idle;

   radar_period_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk     (IN_CLK),
      .rst_n   (IN_RESETN),
      .clear   (ctr_clear),
      .enable  (RUNNING),
      .modulus (act_period),
      .count   (cnt),
      .wrap    (cnt_wrap)
   );

   radar_period_counter #(.WIDTH(AZ_W)) u_az (
      .clk     (IN_CLK),
      .rst_n   (IN_RESETN),
      .clear   (ctr_clear),
      .enable  (cnt_wrap),
      .modulus (act_per_arp),
      .count   (AZIMUTH),
      .wrap    (rev_wrap)
   );

   assign RADAR_ACP = RUNNING && (cnt < PULSE_CNT);
   assign RADAR_ARP = RADAR_ACP && (AZIMUTH == '0);

   assign CFG_READY     = !pend_valid;
   assign cfg_fire      = CFG_VALID && CFG_READY;
   assign cfg_ok        = ({1'b0, CFG_ACP_PERIOD} >= MIN_PERIOD) && (CFG_ACP_PER_ARP != '0);
   assign apply_pending = pend_valid && (rev_wrap || to_idle || (state == ST_IDLE));

   // A handshake can only fire with no pending entry, so a boundary never has to choose between the two.
   always_ff @(posedge IN_CLK) begin
      if (!IN_RESETN) begin
         act_period   <= CNT_W'(DEF_ACP_PERIOD);
         act_per_arp  <= AZ_W'(DEF_ACP_PER_ARP);
         pend_period  <= '0;
         pend_per_arp <= '0;
         pend_valid   <= 1'b0;
         CFG_ERR      <= 1'b0;
      end else begin
         CFG_ERR <= cfg_fire && !cfg_ok;
         if (apply_pending) begin
            act_period  <= pend_period;
            act_per_arp <= pend_per_arp;
            pend_valid  <= 1'b0;
         end
         if (cfg_fire && cfg_ok) begin
            if (state == ST_IDLE) begin
               act_period  <= CFG_ACP_PERIOD;
               act_per_arp <= CFG_ACP_PER_ARP;
            end else begin
               pend_period  <= CFG_ACP_PERIOD;
               pend_per_arp <= CFG_ACP_PER_ARP;
               pend_valid   <= 1'b1;
            end
         end
      end
   end

endmodule
